// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bundle.
// EX side drives ex_*; the stage returns mem_* and backpressure.
interface ex_mem_stage_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_less;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;
    logic        stall_in;
    logic        flush_in;
    logic        ex_stall_out;
    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic        mem_zero;
    logic        mem_less;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [31:0] mem_store_data;
    logic [31:0] mem_pc;

    modport master (
        output ex_valid, ex_pc, alu_out, alu_zero,
        output alu_overflow, alu_less, ex_rd,
        output ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_store_data, stall_in, flush_in,
        input  ex_stall_out, mem_valid, mem_alu_out,
        input  mem_zero, mem_less, mem_rd,
        input  mem_reg_write, mem_mem_read,
        input  mem_mem_write, mem_store_data, mem_pc
    );

    modport slave (
        input  ex_valid, ex_pc, alu_out, alu_zero,
        input  alu_overflow, alu_less, ex_rd,
        input  ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_store_data, stall_in, flush_in,
        output ex_stall_out, mem_valid, mem_alu_out,
        output mem_zero, mem_less, mem_rd,
        output mem_reg_write, mem_mem_read,
        output mem_mem_write, mem_store_data, mem_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with overflow trap.
// Counts retired instructions entering MEM.
module ex_mem_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    ex_mem_stage_if.slave    bus,
    input  logic             exc_ack,
    output logic             exc_valid,
    output logic [31:0]      exc_pc,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic {RUN, TRAP} state_t;

    state_t state;
    logic   take;

    // EX/ID must freeze in the same cycle MEM does.
    assign bus.ex_stall_out = bus.stall_in;

    // Instruction eligible to enter MEM (or to trap).
    assign take = (state == RUN) && !bus.flush_in
               && bus.ex_valid;

    // Pipeline registers, trap state and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= RUN;
            bus.mem_valid      <= 1'b0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            bus.mem_alu_out    <= '0;
            bus.mem_zero       <= 1'b0;
            bus.mem_less       <= 1'b0;
            bus.mem_rd         <= '0;
            bus.mem_store_data <= '0;
            bus.mem_pc         <= '0;
            exc_valid          <= 1'b0;
            exc_pc             <= '0;
            retired            <= '0;
        end else begin
            // Ack is honoured even while stalled.
            if (state == TRAP && exc_ack) begin
                exc_valid <= 1'b0;
                state     <= RUN;
            end
            if (!bus.stall_in) begin
                bus.mem_valid     <= 1'b0;
                bus.mem_reg_write <= 1'b0;
                bus.mem_mem_read  <= 1'b0;
                bus.mem_mem_write <= 1'b0;
                if (take && bus.alu_overflow) begin
                    exc_valid <= 1'b1;
                    exc_pc    <= bus.ex_pc;
                    state     <= TRAP;
                end else if (take) begin
                    bus.mem_valid      <= 1'b1;
                    bus.mem_reg_write  <= bus.ex_reg_write;
                    bus.mem_mem_read   <= bus.ex_mem_read;
                    bus.mem_mem_write  <= bus.ex_mem_write;
                    bus.mem_alu_out    <= bus.alu_out;
                    bus.mem_zero       <= bus.alu_zero;
                    bus.mem_less       <= bus.alu_less;
                    bus.mem_rd         <= bus.ex_rd;
                    bus.mem_store_data <= bus.ex_store_data;
                    bus.mem_pc         <= bus.ex_pc;
                    retired            <= retired + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// Retire counter built 4 bits wide to exercise wrap.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        exc_ack;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [3:0]  retired;
    logic [3:0]  exp_ret;
    int          n_chk = 0;
    int          n_fail = 0;

    ex_mem_stage_if bus ();

    ex_mem_stage #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .exc_ack   (exc_ack),
        .exc_valid (exc_valid),
        .exc_pc    (exc_pc),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, got no finish, need finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid      = 1'b0;
        bus.ex_pc         = 32'h0;
        bus.alu_out       = 32'h0;
        bus.alu_zero      = 1'b0;
        bus.alu_overflow  = 1'b0;
        bus.alu_less      = 1'b0;
        bus.ex_rd         = 5'd0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_store_data = 32'h0;
        bus.stall_in      = 1'b0;
        bus.flush_in      = 1'b0;
        exc_ack           = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc,
                         input logic [31:0] alu,
                         input logic [4:0]  rd,
                         input logic        ovf);
        bus.ex_valid     = 1'b1;
        bus.ex_pc        = pc;
        bus.alu_out      = alu;
        bus.ex_rd        = rd;
        bus.ex_reg_write = 1'b1;
        bus.alu_overflow = ovf;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #12;
        n_chk++;
        if (bus.mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b need 0", bus.mem_valid);
        end
        n_chk++;
        if (retired !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_retired got %0d need 0", retired);
        end
        n_chk++;
        if (exc_valid !== 1'b0 || exc_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_exc got %b/%h need 0/0",
                     exc_valid, exc_pc);
        end
        n_chk++;
        if (bus.mem_alu_out !== 32'h0 || bus.mem_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h need 0/0",
                     bus.mem_alu_out, bus.mem_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
    endtask

    task automatic test_capture();
        drive(32'h0040_0000, 32'h0000_0010, 5'd5, 1'b0);
        bus.alu_less      = 1'b1;
        bus.ex_store_data = 32'hdead_beef;
        step();
        exp_ret = exp_ret + 4'd1;
        n_chk++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 32'h10
            || bus.mem_rd !== 5'd5) begin
            n_fail++;
            $display("FAIL cap_main got v=%b a=%h rd=%0d need 1/10/5",
                     bus.mem_valid, bus.mem_alu_out, bus.mem_rd);
        end
        n_chk++;
        if (bus.mem_reg_write !== 1'b1 || bus.mem_less !== 1'b1
            || bus.mem_store_data !== 32'hdead_beef
            || bus.mem_pc !== 32'h0040_0000) begin
            n_fail++;
            $display("FAIL cap_side got rw=%b l=%b sd=%h pc=%h",
                     bus.mem_reg_write, bus.mem_less,
                     bus.mem_store_data, bus.mem_pc);
        end
        n_chk++;
        if (retired !== 4'd1) begin
            n_fail++;
            $display("FAIL cap_retired got %0d need 1", retired);
        end
        idle();
        bus.alu_overflow = 1'b1;
        step();
        n_chk++;
        if (bus.mem_valid !== 1'b0 || bus.mem_reg_write !== 1'b0
            || exc_valid !== 1'b0 || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL bubble_ovf got v=%b rw=%b e=%b r=%0d need 0/0/0/%0d",
                     bus.mem_valid, bus.mem_reg_write,
                     exc_valid, retired, exp_ret);
        end
        idle();
    endtask

    task automatic test_stall();
        drive(32'h0040_0004, 32'h0000_0020, 5'd7, 1'b0);
        step();
        exp_ret = exp_ret + 4'd1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + i, 32'h55 + i, 5'(i + 9), i == 1);
            bus.flush_in = (i == 2);
            bus.stall_in = 1'b1;
            #1;
            n_chk++;
            if (bus.ex_stall_out !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_out got %b need 1",
                         bus.ex_stall_out);
            end
            step();
            n_chk++;
            if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 32'h20
                || bus.mem_rd !== 5'd7 || retired !== exp_ret
                || exc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b a=%h rd=%0d r=%0d e=%b",
                         i, bus.mem_valid, bus.mem_alu_out,
                         bus.mem_rd, retired, exc_valid);
            end
        end
        idle();
        #1;
        n_chk++;
        if (bus.ex_stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got %b need 0",
                     bus.ex_stall_out);
        end
    endtask

    task automatic test_flush();
        drive(32'h0040_0008, 32'h1234, 5'd3, 1'b0);
        bus.ex_mem_write = 1'b1;
        bus.flush_in     = 1'b1;
        step();
        n_chk++;
        if (bus.mem_valid !== 1'b0 || bus.mem_mem_write !== 1'b0
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL flush got v=%b mw=%b r=%0d need 0/0/%0d",
                     bus.mem_valid, bus.mem_mem_write,
                     retired, exp_ret);
        end
        idle();
    endtask

    task automatic test_trap();
        drive(32'h0040_0020, 32'h7fff_ffff, 5'd4, 1'b1);
        step();
        n_chk++;
        if (bus.mem_valid !== 1'b0 || bus.mem_reg_write !== 1'b0
            || exc_valid !== 1'b1 || exc_pc !== 32'h0040_0020) begin
            n_fail++;
            $display("FAIL trap_enter got v=%b rw=%b e=%b pc=%h",
                     bus.mem_valid, bus.mem_reg_write,
                     exc_valid, exc_pc);
        end
        for (int i = 0; i < 2; i++) begin
            drive(32'h0040_0024 + 4 * i, 32'h99, 5'd6, 1'b0);
            step();
            n_chk++;
            if (bus.mem_valid !== 1'b0 || exc_valid !== 1'b1
                || exc_pc !== 32'h0040_0020 || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL trap_discard%0d got v=%b e=%b pc=%h r=%0d",
                         i, bus.mem_valid, exc_valid, exc_pc, retired);
            end
        end
        drive(32'h0040_002c, 32'h98, 5'd6, 1'b0);
        exc_ack = 1'b1;
        step();
        n_chk++;
        if (exc_valid !== 1'b0 || bus.mem_valid !== 1'b0
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL trap_ack got e=%b v=%b r=%0d need 0/0/%0d",
                     exc_valid, bus.mem_valid, retired, exp_ret);
        end
        exc_ack = 1'b0;
        drive(32'h0040_0030, 32'h30, 5'd8, 1'b0);
        step();
        exp_ret = exp_ret + 4'd1;
        n_chk++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 32'h30
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL trap_resume got v=%b a=%h r=%0d need 1/30/%0d",
                     bus.mem_valid, bus.mem_alu_out, retired, exp_ret);
        end
        drive(32'h0040_0034, 32'h34, 5'd9, 1'b0);
        exc_ack = 1'b1;
        step();
        exp_ret = exp_ret + 4'd1;
        n_chk++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 32'h34
            || exc_valid !== 1'b0 || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL ack_in_run got v=%b a=%h e=%b r=%0d",
                     bus.mem_valid, bus.mem_alu_out,
                     exc_valid, retired);
        end
        idle();
    endtask

    task automatic test_ack_stall();
        drive(32'h0040_0040, 32'h1, 5'd1, 1'b1);
        step();
        drive(32'h0040_0044, 32'h2, 5'd2, 1'b0);
        bus.stall_in = 1'b1;
        exc_ack      = 1'b1;
        step();
        n_chk++;
        if (exc_valid !== 1'b0 || bus.mem_valid !== 1'b0
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL ack_stall got e=%b v=%b r=%0d need 0/0/%0d",
                     exc_valid, bus.mem_valid, retired, exp_ret);
        end
        idle();
        drive(32'h0040_0048, 32'h48, 5'd10, 1'b0);
        step();
        exp_ret = exp_ret + 4'd1;
        n_chk++;
        if (bus.mem_valid !== 1'b1 || bus.mem_pc !== 32'h0040_0048
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL ack_stall_run got v=%b pc=%h r=%0d",
                     bus.mem_valid, bus.mem_pc, retired);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive(32'h1000 + 4 * i, 32'(i), 5'(i), 1'b0);
            step();
            exp_ret = exp_ret + 4'd1;
            n_chk++;
            if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 32'(i)
                || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL b2b%0d got v=%b a=%h r=%0d need 1/%h/%0d",
                         i, bus.mem_valid, bus.mem_alu_out,
                         retired, i, exp_ret);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive(32'h0040_0050, 32'h5, 5'd5, 1'b1);
        step();
        bus.stall_in = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (exc_valid !== 1'b0 || exc_pc !== 32'h0
            || retired !== 4'd0 || bus.mem_valid !== 1'b0
            || bus.mem_pc !== 32'h0 || bus.mem_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL async_rst got e=%b pc=%h r=%0d v=%b",
                     exc_valid, exc_pc, retired, bus.mem_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 4'd0;
        idle();
        drive(32'h0040_0060, 32'h60, 5'd12, 1'b0);
        step();
        exp_ret = exp_ret + 4'd1;
        n_chk++;
        if (bus.mem_valid !== 1'b1 || exc_valid !== 1'b0
            || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL post_rst got v=%b e=%b r=%0d need 1/0/1",
                     bus.mem_valid, exc_valid, retired);
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        exp_ret = 4'd0;
        idle();
        test_reset();
        test_capture();
        test_stall();
        test_flush();
        test_trap();
        test_ack_stall();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
